lmmi_multi_master: RTL and testbench

- Parametrised LMMI configuration master. One command/response stream is fanned out to N_TGT hard-IP LMMI slave ports (PLL, DPHY, further DPHY/PLL instances).
- Serialises register reads and writes, routes REQUEST to one target, and returns exactly one response per command.
- Sits between the soft config sequencer and the hard IP blocks, all in the SCLK domain. The hard-IP LMMICLK is tied to SCLK at top level.

---
 rtl/lmmi_pkg.sv | 20 ++
 rtl/lmmi_tgt_mux.sv | 30 +++
 rtl/lmmi_multi_master.sv | 182 ++++++++++++++++++
 tb/tb_lmmi_multi_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmmi_pkg.sv
// rtl/lmmi_pkg.sv - shared LMMI master types, default widths and target-index width helper
package lmmi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    RSP     = 2'd3
  } lmmi_state_e;

  localparam int PLL_OFFSET_W  = 7;
  localparam int PLL_DATA_W    = 8;
  localparam int DPHY_OFFSET_W = 5;
  localparam int DPHY_DATA_W   = 4;

  function automatic int tgt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lmmi_tgt_mux.sv
// rtl/lmmi_tgt_mux.sv - selects one target's READY, RDATAVALID and RDATA slice by index
module lmmi_tgt_mux #(
  parameter int N_TGT  = 2,
  parameter int DATA_W = 8,
  parameter int TGT_W  = 1
) (
  input  logic [TGT_W-1:0]        sel,
  input  logic [N_TGT-1:0]        ready,
  input  logic [N_TGT-1:0]        rdata_valid,
  input  logic [N_TGT*DATA_W-1:0] rdata,
  output logic                    sel_ready,
  output logic                    sel_rdata_valid,
  output logic [DATA_W-1:0]       sel_rdata
);

  // An out-of-range index selects nothing, so every output reads as idle.
  always_comb begin
    sel_ready       = 1'b0;
    sel_rdata_valid = 1'b0;
    sel_rdata       = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (int'(sel) == i) begin
        sel_ready       = ready[i];
        sel_rdata_valid = rdata_valid[i];
        sel_rdata       = rdata[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/lmmi_multi_master.sv
// rtl/lmmi_multi_master.sv - single-stream LMMI master fanned out to N_TGT hard-IP targets
// Optional wait timeout enabled by defining LMMI_TIMEOUT_EN.
module lmmi_multi_master
  import lmmi_pkg::*;
#(
  parameter  int N_TGT       = 2,
  parameter  int OFFSET_W    = PLL_OFFSET_W,
  parameter  int DATA_W      = PLL_DATA_W,
  parameter  int TIMEOUT_CYC = 255,
  localparam int TGT_W       = tgt_w(N_TGT)
) (
  input  logic                    SCLK,
  input  logic                    RST,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic [TGT_W-1:0]        CMD_TGT,
  input  logic                    CMD_WRRD_N,
  input  logic [OFFSET_W-1:0]     CMD_OFFSET,
  input  logic [DATA_W-1:0]       CMD_WDATA,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic                    RSP_WRRD_N,
  output logic [DATA_W-1:0]       RSP_RDATA,
  output logic                    RSP_ERR,
  output logic                    LMMIRESET_N,
  output logic [N_TGT-1:0]        LMMIREQUEST,
  output logic                    LMMIWRRD_N,
  output logic [OFFSET_W-1:0]     LMMIOFFSET,
  output logic [DATA_W-1:0]       LMMIWDATA,
  input  logic [N_TGT*DATA_W-1:0] LMMIRDATA,
  input  logic [N_TGT-1:0]        LMMIRDATAVALID,
  input  logic [N_TGT-1:0]        LMMIREADY
);

  if (N_TGT < 1 || N_TGT > 8) begin : g_bad_n_tgt
    $error("lmmi_multi_master: N_TGT must be 1..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("lmmi_multi_master: TIMEOUT_CYC must be at least 1");
  end

  lmmi_state_e         state_q, state_d;
  logic [TGT_W-1:0]    tgt_q, tgt_d;
  logic                wrrd_q, wrrd_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                rstn_q;
  logic                sel_ready, sel_rdv;
  logic [DATA_W-1:0]   sel_rdata;
  logic                expire;

  lmmi_tgt_mux #(
    .N_TGT (N_TGT),
    .DATA_W(DATA_W),
    .TGT_W (TGT_W)
  ) u_tgt_mux (
    .sel            (tgt_q),
    .ready          (LMMIREADY),
    .rdata_valid    (LMMIRDATAVALID),
    .rdata          (LMMIRDATA),
    .sel_ready      (sel_ready),
    .sel_rdata_valid(sel_rdv),
    .sel_rdata      (sel_rdata)
  );

`ifdef LMMI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry is the cycle on which the count would reach TIMEOUT_CYC.
  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = '0;
    if ((state_q == REQ && state_d == REQ) || (state_q == WAIT_RD && state_d == WAIT_RD)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge SCLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  // Holding off CMD_READY until LMMIRESET_N is high keeps it low throughout reset.
  assign CMD_READY   = (state_q == IDLE) && rstn_q;
  assign RSP_VALID   = (state_q == RSP);
  assign RSP_WRRD_N  = wrrd_q;
  assign RSP_RDATA   = rdata_q;
  assign RSP_ERR     = err_q;
  assign LMMIRESET_N = rstn_q;
  assign LMMIWRRD_N  = wrrd_q;
  assign LMMIOFFSET  = offset_q;
  assign LMMIWDATA   = wdata_q;

  always_comb begin
    LMMIREQUEST = '0;
    for (int i = 0; i < N_TGT; i++) begin
      LMMIREQUEST[i] = (state_q == REQ) && (int'(tgt_q) == i);
    end
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    wrrd_d   = wrrd_q;
    offset_d = offset_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          tgt_d    = CMD_TGT;
          wrrd_d   = CMD_WRRD_N;
          offset_d = CMD_OFFSET;
          wdata_d  = CMD_WDATA;
          rdata_d  = '0;
          err_d    = (int'(CMD_TGT) >= N_TGT);
          state_d  = err_d ? RSP : REQ;
        end
      end
      REQ: begin
        // A handshake on the expiry cycle wins over the timeout.
        if (sel_ready) begin
          if (wrrd_q) begin
            state_d = RSP;
          end else if (sel_rdv) begin
            rdata_d = sel_rdata;
            state_d = RSP;
          end else begin
            state_d = WAIT_RD;
          end
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = RSP;
        end
      end
      WAIT_RD: begin
        if (sel_rdv) begin
          rdata_d = sel_rdata;
          state_d = RSP;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (RSP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      wrrd_q   <= 1'b0;
      offset_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rstn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      wrrd_q   <= wrrd_d;
      offset_q <= offset_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rstn_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lmmi_multi_master.sv
// tb/tb_lmmi_multi_master.sv - table-driven and randomized bench for lmmi_multi_master
module tb_lmmi_multi_master;

  localparam int N_TGT = 3;
  localparam int OFFSET_W = 7;
  localparam int DATA_W = 8;
  localparam int TO = 8;
`ifdef LMMI_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  logic                    RST;
  logic                    CMD_VALID, CMD_READY, CMD_WRRD_N;
  logic [1:0]              CMD_TGT;
  logic [OFFSET_W-1:0]     CMD_OFFSET;
  logic [DATA_W-1:0]       CMD_WDATA;
  logic                    RSP_VALID, RSP_READY, RSP_WRRD_N, RSP_ERR;
  logic [DATA_W-1:0]       RSP_RDATA;
  logic                    LMMIRESET_N, LMMIWRRD_N;
  logic [N_TGT-1:0]        LMMIREQUEST, LMMIRDATAVALID, LMMIREADY;
  logic [OFFSET_W-1:0]     LMMIOFFSET;
  logic [DATA_W-1:0]       LMMIWDATA;
  logic [N_TGT*DATA_W-1:0] LMMIRDATA;

  lmmi_multi_master #(
    .N_TGT(N_TGT), .OFFSET_W(OFFSET_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)
  ) dut (
    .SCLK(SCLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TGT(CMD_TGT),
    .CMD_WRRD_N(CMD_WRRD_N), .CMD_OFFSET(CMD_OFFSET), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRRD_N(RSP_WRRD_N),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .LMMIRESET_N(LMMIRESET_N),
    .LMMIREQUEST(LMMIREQUEST), .LMMIWRRD_N(LMMIWRRD_N), .LMMIOFFSET(LMMIOFFSET),
    .LMMIWDATA(LMMIWDATA), .LMMIRDATA(LMMIRDATA), .LMMIRDATAVALID(LMMIRDATAVALID),
    .LMMIREADY(LMMIREADY)
  );

  typedef struct {
    int         tgt;
    bit         wr;
    logic [6:0] off;
    logic [7:0] wd;
    logic [7:0] rd;
    int         rdy_dly;
    int         rdv_dly;
    int         rsp_dly;
    bit         noise;
    bit         exp_err;
    logic [7:0] exp_rdata;
    int         exp_lat;
    int         exp_req;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  function automatic vec_t mk(input int tgt, input bit wr, input logic [6:0] off,
                              input logic [7:0] wd, input logic [7:0] rd, input int rdy_dly,
                              input int rdv_dly, input int rsp_dly, input bit noise,
                              input bit exp_err, input logic [7:0] exp_rdata,
                              input int exp_lat, input int exp_req);
    vec_t v;
    v.tgt = tgt; v.wr = wr; v.off = off; v.wd = wd; v.rd = rd;
    v.rdy_dly = rdy_dly; v.rdv_dly = rdv_dly; v.rsp_dly = rsp_dly; v.noise = noise;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat; v.exp_req = exp_req;
    return v;
  endfunction

  // Reference: outcome of one command from the target's delays alone.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_err = 1'b0; r.exp_rdata = 8'h00;
    if (v.tgt >= N_TGT) begin
      r.exp_err = 1'b1; r.exp_lat = 1; r.exp_req = 0;
    end else if (TO_EN && v.rdy_dly >= TO) begin
      r.exp_err = 1'b1; r.exp_lat = TO + 1; r.exp_req = TO;
    end else begin
      r.exp_req = v.rdy_dly + 1;
      if (v.wr) begin
        r.exp_lat = v.rdy_dly + 2;
      end else if (TO_EN && v.rdv_dly > TO) begin
        r.exp_err = 1'b1; r.exp_lat = v.rdy_dly + 2 + TO;
      end else begin
        r.exp_rdata = v.rd; r.exp_lat = v.rdy_dly + 2 + v.rdv_dly;
      end
    end
    return r;
  endfunction

  task automatic clear_lmmi();
    LMMIREADY = '0; LMMIRDATAVALID = '0; LMMIRDATA = '0;
  endtask

  task automatic run_txn(input vec_t v);
    int k, req_cnt, hs_cyc, hold;
    bit seen_rsp, done, bc_checked;
    k = 1; req_cnt = 0; hs_cyc = -1; hold = 0;
    seen_rsp = 1'b0; done = 1'b0; bc_checked = 1'b0;
    check("cmd_ready_idle", CMD_READY, 1);
    CMD_VALID = 1'b1; CMD_TGT = v.tgt[1:0]; CMD_WRRD_N = v.wr;
    CMD_OFFSET = v.off; CMD_WDATA = v.wd;
    tick();
    CMD_VALID = 1'b0; CMD_OFFSET = 7'($urandom); CMD_WDATA = 8'($urandom);
    CMD_WRRD_N = 1'($urandom); CMD_TGT = 2'($urandom);
    while (!done && k < 300) begin
      clear_lmmi();
      RSP_READY = 1'b0;
      if (v.noise) begin
        for (int i = 0; i < N_TGT; i++) begin
          if (i != v.tgt) begin
            LMMIREADY[i] = 1'($urandom);
            LMMIRDATAVALID[i] = 1'($urandom);
            LMMIRDATA[i*DATA_W +: DATA_W] = 8'hFF;
          end
        end
      end
      if (!seen_rsp) begin
        if (LMMIREQUEST != '0) begin
          req_cnt++;
          if (!bc_checked) begin
            check("req_onehot", 32'(LMMIREQUEST), 32'(1) << v.tgt);
            check("lmmi_offset", 32'(LMMIOFFSET), 32'(v.off));
            check("lmmi_wdata", 32'(LMMIWDATA), 32'(v.wd));
            check("lmmi_wrrd_n", 32'(LMMIWRRD_N), 32'(v.wr));
            bc_checked = 1'b1;
          end
          if (v.tgt < N_TGT && LMMIREQUEST[v.tgt] && req_cnt == v.rdy_dly + 1) begin
            LMMIREADY[v.tgt] = 1'b1;
            hs_cyc = k;
          end
        end
        if (hs_cyc >= 0 && !v.wr && k == hs_cyc + v.rdv_dly) begin
          LMMIRDATAVALID[v.tgt] = 1'b1;
          LMMIRDATA[v.tgt*DATA_W +: DATA_W] = v.rd;
        end
        if (RSP_VALID) begin
          seen_rsp = 1'b1;
          check("rsp_latency", k, v.exp_lat);
          check("req_cycles", req_cnt, v.exp_req);
          check("rsp_wrrd_n", 32'(RSP_WRRD_N), 32'(v.wr));
        end
      end
      if (seen_rsp) begin
        check("rsp_valid_held", 32'(RSP_VALID), 1);
        check("rsp_err", 32'(RSP_ERR), 32'(v.exp_err));
        check("rsp_rdata", 32'(RSP_RDATA), 32'(v.exp_rdata));
        if (hold < v.rsp_dly) begin
          if (v.noise && v.tgt < N_TGT) begin
            LMMIREADY[v.tgt] = 1'b1;
            LMMIRDATAVALID[v.tgt] = 1'b1;
            LMMIRDATA[v.tgt*DATA_W +: DATA_W] = 8'hEE;
          end
          hold++;
        end else begin
          RSP_READY = 1'b1;
          done = 1'b1;
        end
      end
      tick();
      k++;
    end
    RSP_READY = 1'b0;
    clear_lmmi();
    check("txn_completed", 32'(done), 1);
    check("rsp_dropped", 32'(RSP_VALID), 0);
  endtask

  initial begin
    RST = 1'b1; CMD_VALID = 1'b0; CMD_TGT = '0; CMD_WRRD_N = 1'b0;
    CMD_OFFSET = '0; CMD_WDATA = '0; RSP_READY = 1'b0;
    clear_lmmi();
    repeat (3) tick();
    check("rst_cmd_ready", 32'(CMD_READY), 0);
    check("rst_rsp_valid", 32'(RSP_VALID), 0);
    check("rst_rsp_err", 32'(RSP_ERR), 0);
    check("rst_rsp_wrrd_n", 32'(RSP_WRRD_N), 0);
    check("rst_rsp_rdata", 32'(RSP_RDATA), 0);
    check("rst_request", 32'(LMMIREQUEST), 0);
    check("rst_bcast", {LMMIWRRD_N, LMMIOFFSET, LMMIWDATA}, 0);
    check("rst_lmmireset_n", 32'(LMMIRESET_N), 0);
    RST = 1'b0;
    check("rstn_before_edge", 32'(LMMIRESET_N), 0);
    tick();
    check("rstn_after_edge", 32'(LMMIRESET_N), 1);

    //        tgt wr off    wd     rd    rdy rdv rsp nz   err rdata  lat req
    tbl.push_back(mk(1, 1, 7'h12, 8'hA5, 8'h00, 0, 0, 0, 0, 0, 8'h00, 2, 1));
    tbl.push_back(mk(0, 0, 7'h05, 8'h00, 8'h3C, 3, 2, 0, 0, 0, 8'h3C, 7, 4));
    tbl.push_back(mk(0, 0, 7'h33, 8'h00, 8'h5A, 1, 1, 2, 1, 0, 8'h5A, 4, 2));
    tbl.push_back(mk(3, 1, 7'h7F, 8'h11, 8'h00, 0, 0, 5, 1, 1, 8'h00, 1, 0));
    tbl.push_back(mk(2, 0, 7'h01, 8'h00, 8'hC3, 0, 0, 1, 1, 0, 8'hC3, 2, 1));
    tbl.push_back(mk(3, 0, 7'h40, 8'h00, 8'h99, 0, 0, 0, 0, 1, 8'h00, 1, 0));
    tbl.push_back(mk(2, 1, 7'h6A, 8'h5C, 8'h00, 2, 0, 0, 1, 0, 8'h00, 4, 3));
`ifdef LMMI_TIMEOUT_EN
    tbl.push_back(mk(0, 0, 7'h10, 8'h00, 8'h44, 100, 0, 3, 1, 1, 8'h00, 9, 8));
    tbl.push_back(mk(1, 1, 7'h11, 8'h22, 8'h00, 7, 0, 0, 1, 0, 8'h00, 9, 8));
    tbl.push_back(mk(0, 0, 7'h12, 8'h00, 8'h77, 0, 9, 2, 0, 1, 8'h00, 10, 1));
    tbl.push_back(mk(2, 0, 7'h13, 8'h00, 8'h88, 0, 8, 0, 1, 0, 8'h88, 10, 1));
`endif
    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset while waiting for read data aborts the transaction.
    CMD_VALID = 1'b1; CMD_TGT = 2'd1; CMD_WRRD_N = 1'b0; CMD_OFFSET = 7'h21;
    tick();
    CMD_VALID = 1'b0;
    check("abort_req", 32'(LMMIREQUEST), 32'h2);
    LMMIREADY[1] = 1'b1;
    tick();
    LMMIREADY = '0;
    RST = 1'b1;
    tick();
    LMMIRDATAVALID[1] = 1'b1; LMMIRDATA[DATA_W +: DATA_W] = 8'hAB;
    check("abort_req_low", 32'(LMMIREQUEST), 0);
    check("abort_no_rsp", 32'(RSP_VALID), 0);
    check("abort_rstn_low", 32'(LMMIRESET_N), 0);
    RST = 1'b0;
    tick();
    check("abort_rstn_high", 32'(LMMIRESET_N), 1);
    check("abort_idle", 32'(CMD_READY), 1);
    tick();
    check("abort_stray_rdv", 32'(RSP_VALID), 0);
    clear_lmmi();
    run_txn(mk(1, 0, 7'h22, 8'h00, 8'h6D, 1, 1, 0, 0, 0, 8'h6D, 4, 2));

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.tgt = $urandom_range(0, 3);
      v.wr = 1'($urandom);
      v.off = 7'($urandom);
      v.wd = 8'($urandom);
      v.rd = 8'($urandom);
      v.rdy_dly = $urandom_range(0, 5);
      v.rdv_dly = $urandom_range(0, 4);
      v.rsp_dly = $urandom_range(0, 3);
      v.noise = 1'($urandom);
      run_txn(model(v));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
